// File: rtl/filtro_secuenciador_taps.sv
// Tap sequencer feeding the filter multiplier: N-tap sample delay line plus coefficient bank,
// serialising one (sample, coefficient) pair per accepted handshake with first/last tap flags.
module filtro_secuenciador_taps #(
  parameter int N_TAPS = 5,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK_G,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] Muestra,
  input  logic              Muestra_Valid,
  output logic              Muestra_Ready,
  input  logic              Coef_We,
  input  logic [ADDR_W-1:0] Coef_Addr,
  input  logic [DATA_W-1:0] Coef_Data,
  output logic              Coef_Err,
  output logic [DATA_W-1:0] Multiplicando,
  output logic [DATA_W-1:0] Constante,
  output logic              Mult_Valid,
  input  logic              Mult_Ready,
  output logic              Primero,
  output logic              Ultimo
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_TAPS - 1);
  localparam logic [ADDR_W:0]   TAPS_EXT = (ADDR_W + 1)'(N_TAPS);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] x [N_TAPS];
  logic [DATA_W-1:0] c [N_TAPS];

  logic [ADDR_W-1:0] idx_next;
  logic              coef_ok;
  logic              accept;
  logic              transfer;
  logic [DATA_W-1:0] coef0;

  // Handshake qualifiers and next-tap selection
  always_comb begin
    idx_next = idx + {{(ADDR_W-1){1'b0}}, 1'b1};
    coef_ok  = Coef_We && (state == IDLE) && ({1'b0, Coef_Addr} < TAPS_EXT);
    accept   = Muestra_Valid && Muestra_Ready && (state == IDLE);
    transfer = Mult_Valid && Mult_Ready;
    // A coefficient written on the accept edge must already feed tap 0
    if (coef_ok && (Coef_Addr == {ADDR_W{1'b0}})) begin
      coef0 = Coef_Data;
    end else begin
      coef0 = c[0];
    end
  end

  // Delay line shift on accept and coefficient bank writes
  always_ff @(posedge CLK_G or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < N_TAPS; k++) begin
        x[k] <= {DATA_W{1'b0}};
        c[k] <= {DATA_W{1'b0}};
      end
    end else begin
      if (accept) begin
        x[0] <= Muestra;
        for (int k = 1; k < N_TAPS; k++) begin
          x[k] <= x[k-1];
        end
      end
      if (coef_ok) begin
        c[Coef_Addr] <= Coef_Data;
      end
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge CLK_G or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      idx           <= {ADDR_W{1'b0}};
      Muestra_Ready <= 1'b1;
      Mult_Valid    <= 1'b0;
      Multiplicando <= {DATA_W{1'b0}};
      Constante     <= {DATA_W{1'b0}};
      Primero       <= 1'b0;
      Ultimo        <= 1'b0;
      Coef_Err      <= 1'b0;
    end else begin
      Coef_Err <= Coef_We && !coef_ok;
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= RUN;
            idx           <= {ADDR_W{1'b0}};
            Muestra_Ready <= 1'b0;
            Mult_Valid    <= 1'b1;
            Multiplicando <= Muestra;
            Constante     <= coef0;
            Primero       <= 1'b1;
            Ultimo        <= 1'b0;
          end
        end
        RUN: begin
          if (transfer) begin
            if (idx == LAST_IDX) begin
              state         <= IDLE;
              idx           <= {ADDR_W{1'b0}};
              Muestra_Ready <= 1'b1;
              Mult_Valid    <= 1'b0;
              Primero       <= 1'b0;
              Ultimo        <= 1'b0;
            end else begin
              idx           <= idx_next;
              Multiplicando <= x[idx_next];
              Constante     <= c[idx_next];
              Primero       <= 1'b0;
              Ultimo        <= (idx_next == LAST_IDX);
            end
          end
        end
        default: begin
          state         <= IDLE;
          idx           <= {ADDR_W{1'b0}};
          Muestra_Ready <= 1'b1;
          Mult_Valid    <= 1'b0;
          Primero       <= 1'b0;
          Ultimo        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_secuenciador_taps.sv
// Self-checking bench: directed scenarios plus random traffic compared every cycle against
// a queue-based model of the expected (sample, coefficient) pair stream.
module tb_filtro_secuenciador_taps;

  localparam int N = 5;

  logic        CLK_G = 1'b0;
  logic        RST_N;
  logic [15:0] Muestra;
  logic        Muestra_Valid;
  logic        Muestra_Ready;
  logic        Coef_We;
  logic [2:0]  Coef_Addr;
  logic [15:0] Coef_Data;
  logic        Coef_Err;
  logic [15:0] Multiplicando;
  logic [15:0] Constante;
  logic        Mult_Valid;
  logic        Mult_Ready;
  logic        Primero;
  logic        Ultimo;

  filtro_secuenciador_taps dut (
    .CLK_G(CLK_G), .RST_N(RST_N),
    .Muestra(Muestra), .Muestra_Valid(Muestra_Valid), .Muestra_Ready(Muestra_Ready),
    .Coef_We(Coef_We), .Coef_Addr(Coef_Addr), .Coef_Data(Coef_Data), .Coef_Err(Coef_Err),
    .Multiplicando(Multiplicando), .Constante(Constante), .Mult_Valid(Mult_Valid),
    .Mult_Ready(Mult_Ready), .Primero(Primero), .Ultimo(Ultimo)
  );

  always #5 CLK_G = ~CLK_G;

  typedef struct packed {
    logic [15:0] m;
    logic [15:0] c;
    logic        p;
    logic        u;
  } pair_t;

  pair_t       q[$];
  logic [15:0] hist [N];
  logic [15:0] coef [N];
  logic        err_exp;
  int          checks = 0;
  int          errors = 0;
  int          accepts = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < N; k++) begin
      hist[k] = 16'd0;
      coef[k] = 16'd0;
    end
    err_exp = 1'b0;
  endtask

  // Abstract model: an idle block has no pending pairs; an accept enqueues all N pairs at once
  task automatic model_edge();
    bit idle;
    idle = (q.size() == 0);
    err_exp = 1'b0;
    if (Coef_We) begin
      if (idle && int'(Coef_Addr) < N) coef[Coef_Addr] = Coef_Data;
      else err_exp = 1'b1;
    end
    if (!idle && Mult_Ready) begin
      void'(q.pop_front());
    end else if (idle && Muestra_Valid) begin
      for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = Muestra;
      for (int k = 0; k < N; k++) q.push_back('{m: hist[k], c: coef[k], p: (k == 0), u: (k == N - 1)});
      accepts++;
    end
  endtask

  task automatic check_all();
    chk("mult_valid", 32'(Mult_Valid), 32'(q.size() != 0));
    chk("muestra_ready", 32'(Muestra_Ready), 32'(q.size() == 0));
    chk("coef_err", 32'(Coef_Err), 32'(err_exp));
    if (q.size() != 0) begin
      chk("multiplicando", $signed(Multiplicando), $signed(q[0].m));
      chk("constante", $signed(Constante), $signed(q[0].c));
      chk("primero", 32'(Primero), 32'(q[0].p));
      chk("ultimo", 32'(Ultimo), 32'(q[0].u));
    end
  endtask

  task automatic step();
    @(posedge CLK_G);
    model_edge();
    @(negedge CLK_G);
    check_all();
  endtask

  task automatic run_out();
    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    chk("run_out_done", q.size(), 0);
  endtask

  task automatic feed(input logic [15:0] s);
    Muestra = s;
    Muestra_Valid = 1'b1;
    step();
    Muestra_Valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int low;
    int cnt;
    int a0;
    RST_N = 1'b0;
    Muestra = 16'd0;
    Muestra_Valid = 1'b0;
    Coef_We = 1'b0;
    Coef_Addr = 3'd0;
    Coef_Data = 16'd0;
    Mult_Ready = 1'b1;
    model_reset();
    @(negedge CLK_G);
    @(negedge CLK_G);
    check_all();
    chk("reset_mult_data", 32'(Multiplicando), 32'd0);
    chk("reset_primero_ultimo", 32'({Primero, Ultimo}), 32'd0);
    RST_N = 1'b1;

    // Load c = {1,2,3,4,5}
    for (int k = 0; k < N; k++) begin
      Coef_We = 1'b1;
      Coef_Addr = 3'(k);
      Coef_Data = 16'(k + 1);
      step();
    end
    Coef_We = 1'b0;

    feed(16'd100);
    chk("lit_run1_m0", $signed(q[0].m), 100);
    chk("lit_run1_m1", $signed(q[1].m), 0);
    chk("lit_run1_c0", $signed(q[0].c), 1);
    chk("lit_run1_c4", $signed(q[4].c), 5);
    low = (Muestra_Ready == 1'b0) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (Muestra_Ready == 1'b0) low++;
    end
    chk("ready_low_cycles", low, 5);

    feed(-16'sd7);
    chk("lit_run2_m0", $signed(q[0].m), -7);
    chk("lit_run2_m1", $signed(q[1].m), 100);
    chk("lit_run2_c1", $signed(q[1].c), 2);
    run_out();

    // Backpressure on tap 2 for three edges
    feed(16'd55);
    chk("lit_run3_m2", $signed(q[2].m), 100);
    cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      Mult_Ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      step();
      if (Mult_Valid && Constante == 16'd3) cnt++;
    end
    Mult_Ready = 1'b1;
    chk("tap2_hold_cycles", cnt, 4);
    chk("bp_done", q.size(), 0);

    // Rejected coefficient writes
    feed(16'd3);
    Coef_We = 1'b1; Coef_Addr = 3'd1; Coef_Data = 16'd999;
    step();
    Coef_We = 1'b0;
    chk("coef_err_run_lit", 32'(Coef_Err), 32'd1);
    step();
    chk("coef_err_run_end", 32'(Coef_Err), 32'd0);
    run_out();
    Coef_We = 1'b1; Coef_Addr = 3'd6; Coef_Data = 16'd77;
    step();
    Coef_We = 1'b0;
    chk("coef_err_addr_lit", 32'(Coef_Err), 32'd1);
    step();
    chk("coef_err_addr_end", 32'(Coef_Err), 32'd0);
    chk("coef1_kept", $signed(coef[1]), 2);

    // Write and accept on the same edge
    Coef_We = 1'b1; Coef_Addr = 3'd0; Coef_Data = 16'd11;
    feed(16'd9);
    Coef_We = 1'b0;
    chk("coef_same_edge", $signed(q[0].c), 11);
    run_out();

    // Muestra_Valid held high
    a0 = accepts;
    Muestra_Valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      Muestra = 16'($urandom);
      step();
    end
    Muestra_Valid = 1'b0;
    chk("continuous_accepts", accepts - a0, 5);
    run_out();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      Muestra = 16'($urandom);
      Muestra_Valid = ($urandom_range(0, 3) != 0);
      Mult_Ready = ($urandom_range(0, 9) < 7);
      Coef_We = ($urandom_range(0, 9) == 0);
      Coef_Addr = 3'($urandom_range(0, 7));
      Coef_Data = 16'($urandom);
      step();
    end
    Muestra_Valid = 1'b0;
    Coef_We = 1'b0;
    Mult_Ready = 1'b1;
    run_out();

    // Asynchronous reset in the middle of a run
    feed(16'd5);
    step();
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_async_valid", 32'(Mult_Valid), 32'd0);
    chk("rst_async_ready", 32'(Muestra_Ready), 32'd1);
    model_reset();
    @(negedge CLK_G);
    check_all();
    RST_N = 1'b1;
    feed(16'd42);
    chk("post_rst_m0", $signed(q[0].m), 42);
    chk("post_rst_c0", $signed(q[0].c), 0);
    chk("post_rst_m1", $signed(q[1].m), 0);
    run_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
